m68k_bus_arbiter: RTL

M68K_BUS_ARBITER -- requirements
Module: m68k_bus_arbiter

---
 rtl/m68k_bus_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/m68k_bus_arbiter.sv
// 68K-style bus arbiter: hands the local bus to one of NCH DMA channels via
// the BR/BG/BGACK handshake, round-robin between requesters, with a grant
// acknowledge timeout and an over-long hold alarm.
module m68k_bus_arbiter #(
  parameter int NCH      = 2,
  parameter int ACK_TO   = 15,
  parameter int HOLD_MAX = 255,
  localparam int OW      = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           bgreset,
  input  logic           cpu_cycle_end,
  input  logic           cpu_idle,
  input  logic [NCH-1:0] br_n,
  input  logic [NCH-1:0] bgack_n,
  output logic [NCH-1:0] bg_n,
  output logic           bus_granted,
  output logic [OW-1:0]  owner,
  output logic           ack_err,
  output logic           hold_err
);

  localparam int AW = (ACK_TO > 1) ? $clog2(ACK_TO) : 1;
  localparam int HW = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_OWNED, S_REL} state_e;

  state_e         state_q, state_d;
  logic [NCH-1:0] br_s1_q, br_s2_q, ack_s1_q, ack_s2_q;
  logic [NCH-1:0] brs, acks;
  logic [OW-1:0]  owner_q, owner_d, last_owner_q, last_owner_d;
  logic [OW-1:0]  sel, hi_sel, lo_sel;
  logic           hi_found;
  logic [AW-1:0]  ack_cnt_q, ack_cnt_d;
  logic [HW-1:0]  hold_cnt_q, hold_cnt_d;
  logic           ack_to_hit, hold_hit;
  logic [NCH-1:0] bg_n_q, bg_n_d;
  logic           bus_granted_q, bus_granted_d;
  logic           ack_err_q, ack_err_d, hold_err_q, hold_err_d;

  // Two-flop synchronisers for the asynchronous active-low handshake inputs
  always_ff @(posedge clk or posedge bgreset) begin
    if (bgreset) begin
      br_s1_q  <= '1;
      br_s2_q  <= '1;
      ack_s1_q <= '1;
      ack_s2_q <= '1;
    end else begin
      br_s1_q  <= br_n;
      br_s2_q  <= br_s1_q;
      ack_s1_q <= bgack_n;
      ack_s2_q <= ack_s1_q;
    end
  end

  assign brs  = ~br_s2_q;
  assign acks = ~ack_s2_q;

  // Round-robin pick: lowest requester above last_owner, else lowest overall (wrap)
  always_comb begin
    hi_found = 1'b0;
    hi_sel   = '0;
    lo_sel   = '0;
    for (int j = NCH - 1; j >= 0; j--) begin
      if (brs[j]) begin
        if (j > int'(last_owner_q)) begin
          hi_found = 1'b1;
          hi_sel   = OW'(j);
        end
        lo_sel = OW'(j);
      end
    end
    sel = hi_found ? hi_sel : lo_sel;
  end

  // FSM state register
  always_ff @(posedge clk or posedge bgreset) begin
    if (bgreset) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // FSM next state; only the owner's request/ack matter once out of IDLE
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    ack_to_hit   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if ((|brs) && (cpu_idle || cpu_cycle_end)) begin
          state_d = S_GRANT;
          owner_d = sel;
        end
      end
      S_GRANT: begin
        if (acks[owner_q])                       state_d = S_OWNED;
        else if (!brs[owner_q])                  state_d = S_IDLE;
        else if (ack_cnt_q == AW'(ACK_TO - 1)) begin
          state_d    = S_IDLE;
          ack_to_hit = 1'b1;
        end
      end
      S_OWNED: begin
        if (!acks[owner_q]) state_d = S_REL;
      end
      S_REL: begin
        state_d      = S_IDLE;
        last_owner_d = owner_q;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs and counters, all computed from next state so outputs are registered
  always_comb begin
    bg_n_d = '1;
    if (state_d == S_GRANT) bg_n_d[owner_d] = 1'b0;
    bus_granted_d = (state_d != S_IDLE);
    ack_cnt_d     = (state_q == S_GRANT && state_d == S_GRANT) ? ack_cnt_q + 1'b1 : '0;
    hold_cnt_d    = '0;
    if (state_q == S_OWNED)
      hold_cnt_d = (hold_cnt_q != HW'(HOLD_MAX)) ? hold_cnt_q + 1'b1 : hold_cnt_q;
    hold_hit   = (HOLD_MAX != 0) && (state_q == S_OWNED) && (hold_cnt_q == HW'(HOLD_MAX - 1));
    ack_err_d  = ack_to_hit;
    hold_err_d = hold_hit;
  end

  // Datapath and output registers; async reset drops any grant immediately
  always_ff @(posedge clk or posedge bgreset) begin
    if (bgreset) begin
      owner_q       <= '0;
      last_owner_q  <= OW'(NCH - 1);
      ack_cnt_q     <= '0;
      hold_cnt_q    <= '0;
      bg_n_q        <= '1;
      bus_granted_q <= 1'b0;
      ack_err_q     <= 1'b0;
      hold_err_q    <= 1'b0;
    end else begin
      owner_q       <= owner_d;
      last_owner_q  <= last_owner_d;
      ack_cnt_q     <= ack_cnt_d;
      hold_cnt_q    <= hold_cnt_d;
      bg_n_q        <= bg_n_d;
      bus_granted_q <= bus_granted_d;
      ack_err_q     <= ack_err_d;
      hold_err_q    <= hold_err_d;
    end
  end

  assign bg_n        = bg_n_q;
  assign bus_granted = bus_granted_q;
  assign owner       = owner_q;
  assign ack_err     = ack_err_q;
  assign hold_err    = hold_err_q;

endmodule
